// File: rtl/arm_fetch_stage.sv
// Instruction-fetch stage: PC, word-indexed instruction store and a registered {pc_out, instruction, valid} stage.
// Optional performance counters are enabled by defining FETCH_PERF_EN.
module arm_fetch_stage #(
   parameter int          IMEM_DEPTH = 256,
   parameter logic [31:0] RESET_PC   = 32'd0,
   parameter logic [31:0] NOP_WORD   = 32'h0000_0000,
   localparam int         AW         = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          stall,
   input  logic          redirect,
   input  logic [31:0]   redirect_pc,
   input  logic          imem_wr_en,
   input  logic [AW-1:0] imem_wr_addr,
   input  logic [31:0]   imem_wr_data,
   output logic [31:0]   pc_out,
   output logic [31:0]   instruction,
   output logic          valid,
   output logic          halted,
   output logic [31:0]   fetch_count,
   output logic [31:0]   redirect_count
);

   typedef enum logic {S_RUN, S_HALT} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pc_out_q, pc_out_d;
   logic [31:0] instr_q, instr_d;
   logic        valid_q, valid_d;
   logic        pc_in_range;

   logic [31:0] imem [IMEM_DEPTH] = '{default: NOP_WORD};

   // NOTE: the store has no reset; the write port alone owns it, so it maps onto plain RAM.
   always_ff @(posedge clock) begin
      if (imem_wr_en) imem[imem_wr_addr] <= imem_wr_data;
   end

   assign pc_in_range = (pc_q < 32'(IMEM_DEPTH));

   // NOTE: every variable gets its hold value first, so no path through this block infers a latch.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      pc_out_d = pc_out_q;
      instr_d  = instr_q;
      valid_d  = valid_q;
      if (redirect) begin
         state_d  = S_RUN;
         pc_d     = redirect_pc;
         pc_out_d = redirect_pc;
         instr_d  = NOP_WORD;
         valid_d  = 1'b0;
      end else if (state_q == S_HALT) begin
         instr_d = NOP_WORD;
         valid_d = 1'b0;
      end else if (stall) begin
         // hold everything
      end else if (!pc_in_range) begin
         state_d = S_HALT;
         instr_d = NOP_WORD;
         valid_d = 1'b0;
      end else begin
         // Read sees the pre-edge store contents, giving read-before-write on a colliding load.
         instr_d  = imem[pc_q[AW-1:0]];
         pc_out_d = pc_q;
         valid_d  = 1'b1;
         pc_d     = pc_q + 32'd1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= S_RUN;
         pc_q     <= RESET_PC;
         pc_out_q <= 32'd0;
         instr_q  <= NOP_WORD;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         pc_out_q <= pc_out_d;
         instr_q  <= instr_d;
         valid_q  <= valid_d;
      end
   end

   assign pc_out      = pc_out_q;
   assign instruction = instr_q;
   assign valid       = valid_q;
   assign halted      = (state_q == S_HALT);

`ifdef FETCH_PERF_EN
   logic [31:0] fetch_cnt_q, redir_cnt_q;
   logic        fetch_evt;

   assign fetch_evt = !redirect && (state_q == S_RUN) && !stall && pc_in_range;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fetch_cnt_q <= 32'd0;
         redir_cnt_q <= 32'd0;
      end else begin
         if (fetch_evt) fetch_cnt_q <= fetch_cnt_q + 32'd1;
         if (redirect)  redir_cnt_q <= redir_cnt_q + 32'd1;
      end
   end

   assign fetch_count    = fetch_cnt_q;
   assign redirect_count = redir_cnt_q;
`else
   assign fetch_count    = 32'd0;
   assign redirect_count = 32'd0;
`endif

endmodule

// File: tb/tb_arm_fetch_stage.sv
// Self-checking bench for arm_fetch_stage (IMEM_DEPTH=16) against a behavioural fetch model.
// Counter expectations follow FETCH_PERF_EN the same way the design does.
module tb_arm_fetch_stage;

   localparam int          DEPTH = 16;
   localparam logic [31:0] NOP   = 32'h0000_0000;

   logic        clock = 1'b0;
   logic        reset, stall, redirect, imem_wr_en;
   logic [31:0] redirect_pc, imem_wr_data;
   logic [3:0]  imem_wr_addr;
   logic [31:0] pc_out, instruction, fetch_count, redirect_count;
   logic        valid, halted;

   int n_cmp = 0;
   int n_bad = 0;

   arm_fetch_stage #(.IMEM_DEPTH(DEPTH), .RESET_PC(32'd0), .NOP_WORD(NOP)) dut (
      .clock(clock), .reset(reset), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .imem_wr_en(imem_wr_en), .imem_wr_addr(imem_wr_addr),
      .imem_wr_data(imem_wr_data), .pc_out(pc_out), .instruction(instruction),
      .valid(valid), .halted(halted), .fetch_count(fetch_count), .redirect_count(redirect_count)
   );

   always #5 clock = ~clock;

   // Behavioural model state
   logic [31:0] mem_m [DEPTH];
   logic [31:0] pc_m, pc_out_m, instr_m, fcnt_m, rcnt_m;
   logic        valid_m, halted_m;

   wire [129:0] observed = {pc_out, instruction, valid, halted, fetch_count, redirect_count};

   function automatic logic [129:0] expected();
`ifdef FETCH_PERF_EN
      return {pc_out_m, instr_m, valid_m, halted_m, fcnt_m, rcnt_m};
`else
      return {pc_out_m, instr_m, valid_m, halted_m, 64'd0};
`endif
   endfunction

   function automatic void model_reset();
      pc_m = 32'd0; pc_out_m = 32'd0; instr_m = NOP;
      valid_m = 1'b0; halted_m = 1'b0; fcnt_m = 32'd0; rcnt_m = 32'd0;
   endfunction

   // One rising edge of the fetch rules; the store update lands after the fetch reads it.
   function automatic void model_step();
      if (redirect) begin
         pc_m = redirect_pc; pc_out_m = redirect_pc; instr_m = NOP;
         valid_m = 1'b0; halted_m = 1'b0; rcnt_m++;
      end else if (!halted_m && !stall) begin
         if (pc_m >= DEPTH) begin
            halted_m = 1'b1; valid_m = 1'b0; instr_m = NOP;
         end else begin
            instr_m = mem_m[pc_m[3:0]]; pc_out_m = pc_m; valid_m = 1'b1;
            pc_m++; fcnt_m++;
         end
      end
      if (imem_wr_en) mem_m[imem_wr_addr] = imem_wr_data;
   endfunction

   task automatic drive(input logic st, input logic rd, input logic [31:0] rpc,
                        input logic we, input logic [3:0] wa, input logic [31:0] wd);
      stall = st; redirect = rd; redirect_pc = rpc;
      imem_wr_en = we; imem_wr_addr = wa; imem_wr_data = wd;
   endtask

   task automatic tick();
      @(posedge clock);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      drive(0, 0, 0, 0, 0, 0);
      reset = 1'b1;
      model_reset();
      for (int i = 0; i < DEPTH; i++) mem_m[i] = NOP;
      #2;
      n_cmp++;
      if (observed !== expected()) begin
         n_bad++; $display("FAIL reset_async: got %h want %h", observed, expected());
      end
      @(posedge clock); #1;
      n_cmp++;
      if (observed !== expected()) begin
         n_bad++; $display("FAIL reset_held: got %h want %h", observed, expected());
      end
      reset = 1'b0;
   endtask

   task automatic test_load_run();
      logic [31:0] words [3];
      words[0] = 32'h8B020029; words[1] = 32'hF841006A; words[2] = 32'hCB0A012B;
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 0, 1, 4'(i), words[i]);
         tick();
      end
      drive(1, 0, 0, 1, 4'd15, 32'h1234_5678);
      tick();
      n_cmp++;
      if (observed !== expected()) begin
         n_bad++; $display("FAIL load_stalled: got %h want %h", observed, expected());
      end
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 0, 0, 0);
         tick();
         n_cmp++;
         if (pc_out !== 32'(i) || instruction !== words[i] || valid !== 1'b1 ||
             observed !== expected()) begin
            n_bad++;
            $display("FAIL run_%0d: got pc %0d ins %h v %b want pc %0d ins %h v 1",
                     i, pc_out, instruction, valid, i, words[i]);
         end
      end
   endtask

   task automatic test_stall();
      logic [31:0] frozen_pc;
      frozen_pc = pc_out_m;
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 0, 0, 0, 0);
         tick();
         n_cmp++;
         if (observed !== expected() || pc_out !== frozen_pc) begin
            n_bad++; $display("FAIL stall_%0d: got %h want %h", i, observed, expected());
         end
      end
      drive(0, 0, 0, 0, 0, 0);
      tick();
      n_cmp++;
      if (observed !== expected() || pc_out !== frozen_pc + 32'd1) begin
         n_bad++; $display("FAIL stall_release: got %h want %h", observed, expected());
      end
   endtask

   task automatic test_redirect_stall();
      drive(1, 1, 32'd15, 0, 0, 0);
      tick();
      n_cmp++;
      if (valid !== 1'b0 || instruction !== NOP || observed !== expected()) begin
         n_bad++; $display("FAIL redirect_bubble: got %h want %h", observed, expected());
      end
      drive(0, 0, 0, 0, 0, 0);
      tick();
      n_cmp++;
      if (pc_out !== 32'd15 || instruction !== 32'h1234_5678 || observed !== expected()) begin
         n_bad++; $display("FAIL redirect_target: got %h want %h", observed, expected());
      end
   endtask

   task automatic test_halt();
      drive(0, 1, 32'd14, 0, 0, 0);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 0, 0, 0);
         tick();
         n_cmp++;
         if (observed !== expected() || halted !== (i == 2)) begin
            n_bad++; $display("FAIL halt_run_%0d: got %h want %h", i, observed, expected());
         end
      end
      drive(1, 0, 0, 0, 0, 0);
      tick();
      n_cmp++;
      if (halted !== 1'b1 || valid !== 1'b0 || observed !== expected()) begin
         n_bad++; $display("FAIL halt_hold: got %h want %h", observed, expected());
      end
      drive(0, 1, 32'd3, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      tick();
      n_cmp++;
      if (pc_out !== 32'd3 || halted !== 1'b0 || observed !== expected()) begin
         n_bad++; $display("FAIL halt_exit: got %h want %h", observed, expected());
      end
      drive(0, 1, 32'h8000_0000, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      tick();
      n_cmp++;
      if (halted !== 1'b1 || observed !== expected()) begin
         n_bad++; $display("FAIL rehalt_far: got %h want %h", observed, expected());
      end
   endtask

   task automatic test_read_before_write();
      logic [31:0] old_word;
      old_word = mem_m[4];
      drive(0, 1, 32'd4, 0, 0, 0);
      tick();
      drive(0, 0, 0, 1, 4'd4, 32'hAA020020);
      tick();
      n_cmp++;
      if (instruction !== old_word || observed !== expected()) begin
         n_bad++; $display("FAIL rbw_old: got %h want %h", instruction, old_word);
      end
      drive(0, 1, 32'd4, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      tick();
      n_cmp++;
      if (instruction !== 32'hAA020020 || observed !== expected()) begin
         n_bad++; $display("FAIL rbw_new: got %h want aa020020", instruction);
      end
   endtask

   task automatic test_random();
      logic [31:0] tgt;
      for (int i = 0; i < 400; i++) begin
         tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                           : 32'($urandom_range(0, 17));
         drive($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, tgt,
               $urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)), $urandom);
         tick();
         n_cmp++;
         if (observed !== expected()) begin
            n_bad++; $display("FAIL random_%0d: got %h want %h", i, observed, expected());
         end
      end
   endtask

   task automatic test_async_reset();
      drive(0, 1, 32'd0, 0, 0, 0);
      tick();
      drive(1, 0, 0, 0, 0, 0);
      tick();
      tick();
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      n_cmp++;
      if (observed !== expected() || valid !== 1'b0) begin
         n_bad++; $display("FAIL reset_mid_stall: got %h want %h", observed, expected());
      end
      @(posedge clock); #1;
      reset = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) tick();
      drive(0, 1, 32'd2, 0, 0, 0);
      tick();
      n_cmp++;
      if (observed !== expected()) begin
         n_bad++; $display("FAIL perf_counts: got %0d/%0d want %h", fetch_count, redirect_count,
                           expected());
      end
      drive(0, 0, 0, 0, 0, 0);
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      n_cmp++;
      if (observed !== expected() || fetch_count !== 32'd0 || redirect_count !== 32'd0) begin
         n_bad++; $display("FAIL perf_reset: got %0d/%0d want 0/0", fetch_count, redirect_count);
      end
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_load_run();
      test_stall();
      test_redirect_stall();
      test_halt();
      test_read_before_write();
      test_random();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
